// File: rtl/block_dispatch.sv
// Kernel-level block scheduler: sizes the block grid on launch, hands block IDs
// to idle compute units, and reports kernel completion once every block is done.
module block_dispatch #(
  parameter int NUM_CORES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [31:0]               num_threads,
  input  logic [31:0]               block_dim,
  input  logic [NUM_CORES-1:0]      core_block_done,
  output logic [NUM_CORES-1:0]      core_reset,
  output logic [NUM_CORES-1:0]      core_enable,
  output logic [32*NUM_CORES-1:0]   core_block_id,
  output logic                      busy,
  output logic                      kernel_done,
  output logic [1:0]                dbg_state
);

  // Launch handshake: start is accepted only on an edge where the FSM is IDLE;
  // num_threads/block_dim are captured on that same edge, busy rises after it
  // and stays high until kernel_done rises. start at any other time is dropped.

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SLOT_FREE  = 2'd0,
    SLOT_RESET = 2'd1,
    SLOT_RUN   = 2'd2
  } slot_t;

  state_t                    state, state_n;
  slot_t                     slot   [NUM_CORES];
  slot_t                     slot_n [NUM_CORES];
  logic [31:0]               num_blocks, num_blocks_n;
  logic [31:0]               blocks_dispatched, blocks_dispatched_n;
  logic [31:0]               blocks_done, blocks_done_n;
  logic [NUM_CORES-1:0]      core_reset_n, core_enable_n;
  logic [32*NUM_CORES-1:0]   core_block_id_n;
  logic                      busy_n, kernel_done_n;
  logic [31:0]               next_id, done_add;

  // Ceiling division in 33 bits so num_threads + block_dim - 1 cannot wrap.
  logic [32:0] grid_sum, grid_quot;
  logic [31:0] grid_blocks;

  assign grid_sum    = {1'b0, num_threads} + {1'b0, block_dim} - 33'd1;
  assign grid_quot   = grid_sum / {1'b0, block_dim};
  assign grid_blocks = grid_quot[32] ? 32'hFFFF_FFFF : grid_quot[31:0];

  assign dbg_state = state;

  always_comb begin
    state_n             = state;
    slot_n              = slot;
    num_blocks_n        = num_blocks;
    blocks_dispatched_n = blocks_dispatched;
    blocks_done_n       = blocks_done;
    core_reset_n        = core_reset;
    core_enable_n       = core_enable;
    core_block_id_n     = core_block_id;
    busy_n              = busy;
    kernel_done_n       = kernel_done;
    next_id             = blocks_dispatched;
    done_add            = 32'd0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          num_blocks_n        = (num_threads == 32'd0 || block_dim == 32'd0) ? 32'd0 : grid_blocks;
          blocks_dispatched_n = 32'd0;
          blocks_done_n       = 32'd0;
          kernel_done_n       = 1'b0;
          busy_n              = 1'b1;
          state_n             = ST_DISPATCH;
        end
      end

      ST_DISPATCH: begin
        if (blocks_done == num_blocks) begin
          kernel_done_n = 1'b1;
          busy_n        = 1'b0;
          state_n       = ST_DONE;
        end else begin
          // Slots are scanned low to high so IDs go out in ascending core order.
          for (int i = 0; i < NUM_CORES; i++) begin
            case (slot[i])
              SLOT_FREE: begin
                if (next_id < num_blocks) begin
                  core_block_id_n[32*i +: 32] = next_id;
                  core_reset_n[i]             = 1'b1;
                  slot_n[i]                   = SLOT_RESET;
                  next_id                     = next_id + 32'd1;
                end
              end
              SLOT_RESET: begin
                core_reset_n[i]  = 1'b0;
                core_enable_n[i] = 1'b1;
                slot_n[i]        = SLOT_RUN;
              end
              SLOT_RUN: begin
                // Done is only trusted in RUN; a flag left over from the
                // previous block is still high during FREE/RESET.
                if (core_block_done[i]) begin
                  core_enable_n[i]            = 1'b0;
                  core_block_id_n[32*i +: 32] = 32'hFFFF_FFFF;
                  slot_n[i]                   = SLOT_FREE;
                  done_add                    = done_add + 32'd1;
                end
              end
              default: slot_n[i] = SLOT_FREE;
            endcase
          end
          blocks_dispatched_n = next_id;
          blocks_done_n       = blocks_done + done_add;
        end
      end

      ST_DONE: state_n = ST_IDLE;

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= ST_IDLE;
      for (int i = 0; i < NUM_CORES; i++) slot[i] <= SLOT_FREE;
      num_blocks        <= 32'd0;
      blocks_dispatched <= 32'd0;
      blocks_done       <= 32'd0;
      core_reset        <= '0;
      core_enable       <= '0;
      core_block_id     <= '1;
      busy              <= 1'b0;
      kernel_done       <= 1'b0;
    end else begin
      state             <= state_n;
      slot              <= slot_n;
      num_blocks        <= num_blocks_n;
      blocks_dispatched <= blocks_dispatched_n;
      blocks_done       <= blocks_done_n;
      core_reset        <= core_reset_n;
      core_enable       <= core_enable_n;
      core_block_id     <= core_block_id_n;
      busy              <= busy_n;
      kernel_done       <= kernel_done_n;
    end
  end

endmodule

// File: tb/tb_block_dispatch.sv
// Bench for block_dispatch: modelled compute units answer each block, and a
// scoreboard checks dispatch order, pulse shapes and kernel completion timing.
module tb_block_dispatch;
  localparam int NC = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       num_threads = '0;
  logic [31:0]       block_dim = '0;
  logic [NC-1:0]     core_block_done = '0;
  logic [NC-1:0]     core_reset, core_enable;
  logic [32*NC-1:0]  core_block_id;
  logic              busy, kernel_done;
  logic [1:0]        dbg_state;

  block_dispatch #(.NUM_CORES(NC)) dut (
    .clk(clk), .rst(rst), .start(start), .num_threads(num_threads),
    .block_dim(block_dim), .core_block_done(core_block_done),
    .core_reset(core_reset), .core_enable(core_enable),
    .core_block_id(core_block_id), .busy(busy), .kernel_done(kernel_done),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  initial forever @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  // scoreboard state
  logic [31:0] exp_q[$];
  longint      exp_nb;
  int          pulses, dones_seen, last_done_cyc, start_cyc, dual_cnt;
  int          lat_fixed [NC];
  int          cur_lat [NC];
  int          run_cnt [NC];
  bit          stale_hold [NC];
  bit          stale_pending [NC];
  logic [NC-1:0] prev_en = '0, prev_rp = '0;
  logic [31:0] prev_id [NC];
  logic [31:0] mon_id, exp_id;
  int          falls;

  // monitor + unit responder, evaluated away from the active edge
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      prev_en = '0;
      prev_rp = '0;
      core_block_done = '0;
      for (int i = 0; i < NC; i++) begin
        stale_hold[i] = 1'b0;
        stale_pending[i] = 1'b0;
      end
    end else begin
      falls = 0;
      for (int i = 0; i < NC; i++) begin
        mon_id = core_block_id[32*i +: 32];
        checks++;
        if (core_reset[i] && core_enable[i]) begin
          errors++;
          $display("FAIL overlap core%0d: reset=1 enable=1, required not both", i);
        end
        if (core_reset[i]) begin
          pulses++;
          checks++;
          if (prev_rp[i]) begin
            errors++;
            $display("FAIL reset_width core%0d: reset high 2 cycles, required 1", i);
          end
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_dispatch core%0d: got id %0d, required no dispatch", i, $signed(mon_id));
          end else begin
            exp_id = exp_q.pop_front();
            if (mon_id !== exp_id) begin
              errors++;
              $display("FAIL dispatch_id core%0d: got %0d required %0d", i, $signed(mon_id), exp_id);
            end
          end
        end
        if (core_enable[i] && (prev_en[i] || prev_rp[i])) begin
          checks++;
          if (mon_id !== prev_id[i]) begin
            errors++;
            $display("FAIL id_stable core%0d: got %0d required %0d", i, $signed(mon_id), prev_id[i]);
          end
        end
        if (!core_reset[i] && !core_enable[i]) begin
          checks++;
          if (mon_id !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL idle_id core%0d: got %0d required -1", i, $signed(mon_id));
          end
        end
        if (prev_en[i] && !core_enable[i]) begin
          dones_seen++;
          falls++;
          last_done_cyc = cyc;
        end
        // unit model: done is sticky until the unit sees its reset pulse
        if (core_reset[i]) begin
          if (stale_hold[i]) begin
            stale_hold[i] = 1'b0;
            stale_pending[i] = 1'b1;
          end else begin
            core_block_done[i] = 1'b0;
          end
        end else if (stale_pending[i]) begin
          core_block_done[i] = 1'b0;
          stale_pending[i] = 1'b0;
        end
        if (core_enable[i]) begin
          if (!prev_en[i]) begin
            run_cnt[i] = 0;
            cur_lat[i] = (lat_fixed[i] != 0) ? lat_fixed[i] : int'($urandom_range(1, 12));
          end
          run_cnt[i]++;
          if (run_cnt[i] == cur_lat[i]) core_block_done[i] = 1'b1;
        end
        prev_id[i] = mon_id;
      end
      if (falls == NC) dual_cnt++;
      prev_en = core_enable;
      prev_rp = core_reset;
    end
  end

  // driver tasks
  task automatic launch(input logic [31:0] n, input logic [31:0] d, input string name);
    repeat (2) @(negedge clk);
    exp_nb = (n == 0 || d == 0) ? 0 : (longint'(n) + longint'(d) - 1) / longint'(d);
    exp_q.delete();
    for (longint k = 0; k < exp_nb; k++) exp_q.push_back(k[31:0]);
    pulses = 0;
    dones_seen = 0;
    dual_cnt = 0;
    last_done_cyc = -1;
    start = 1'b1;
    num_threads = n;
    block_dim = d;
    @(negedge clk);
    start = 1'b0;
    num_threads = $urandom;
    block_dim = $urandom;
    start_cyc = cyc;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b required 1", name, busy);
    end
    checks++;
    if (kernel_done !== 1'b0) begin
      errors++;
      $display("FAIL %s kd_cleared: got %b required 0", name, kernel_done);
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int k = 0; k < budget && !kernel_done; k++) @(negedge clk);
    checks++;
    if (kernel_done !== 1'b1) begin
      errors++;
      $display("FAIL %s kd_timeout: got %b required 1 within %0d cycles", name, kernel_done, budget);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
    end else begin
      checks++;
      if (exp_nb == 0) begin
        if (cyc != start_cyc + 1) begin
          errors++;
          $display("FAIL %s kd_timing: got edge %0d required %0d", name, cyc, start_cyc + 1);
        end
      end else if (cyc != last_done_cyc + 1) begin
        errors++;
        $display("FAIL %s kd_timing: got edge %0d required %0d", name, cyc, last_done_cyc + 1);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_at_done: got %b required 0", name, busy);
      end
      checks++;
      if (longint'(dones_seen) != exp_nb) begin
        errors++;
        $display("FAIL %s done_count: got %0d required %0d", name, dones_seen, exp_nb);
      end
      checks++;
      if (longint'(pulses) != exp_nb) begin
        errors++;
        $display("FAIL %s reset_pulses: got %0d required %0d", name, pulses, exp_nb);
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL %s undispatched: got %0d left required 0", name, exp_q.size());
      end
      repeat (3) @(negedge clk);
      checks++;
      if (kernel_done !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s kd_sticky: got kd=%b busy=%b required kd=1 busy=0", name, kernel_done, busy);
      end
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (core_reset !== '0 || core_enable !== '0 || core_block_id !== '1 ||
        busy !== 1'b0 || kernel_done !== 1'b0) begin
      errors++;
      $display("FAIL %s: got rst=%b en=%b id=%h busy=%b kd=%b required 0/0/all-ones/0/0",
               name, core_reset, core_enable, core_block_id, busy, kernel_done);
    end
  endtask

  // scenario tasks
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset_held");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("reset_released");
  endtask

  task automatic test_basic();
    lat_fixed[0] = 10;
    lat_fixed[1] = 10;
    launch(32'd256, 32'd64, "basic");
    @(negedge clk);
    checks++;
    if (core_reset !== 2'b11 || core_block_id[31:0] !== 32'd0 || core_block_id[63:32] !== 32'd1) begin
      errors++;
      $display("FAIL basic first_dispatch: got rst=%b id0=%0d id1=%0d required 11/0/1",
               core_reset, $signed(core_block_id[31:0]), $signed(core_block_id[63:32]));
    end
    @(negedge clk);
    checks++;
    if (core_enable !== 2'b11 || core_reset !== 2'b00) begin
      errors++;
      $display("FAIL basic enable_phase: got en=%b rst=%b required 11/00", core_enable, core_reset);
    end
    wait_done(300, "basic");
  endtask

  task automatic test_partial();
    lat_fixed[0] = 20;
    lat_fixed[1] = 5;
    launch(32'd100, 32'd64, "partial");
    wait_done(300, "partial");
  endtask

  task automatic test_simultaneous_stale();
    lat_fixed[0] = 6;
    lat_fixed[1] = 6;
    stale_hold[0] = 1'b1;
    launch(32'd256, 32'd64, "sim_stale");
    repeat (3) @(negedge clk);
    stale_hold[0] = 1'b1;
    wait_done(300, "sim_stale");
    checks++;
    if (dual_cnt < 1) begin
      errors++;
      $display("FAIL sim_stale dual_done: got %0d same-edge completions required >=1", dual_cnt);
    end
  endtask

  task automatic test_zero_grid();
    lat_fixed[0] = 3;
    lat_fixed[1] = 3;
    launch(32'd1000, 32'd0, "zero_dim");
    wait_done(10, "zero_dim");
    launch(32'd0, 32'd64, "zero_threads");
    wait_done(10, "zero_threads");
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max_one");
    wait_done(100, "max_one");
    launch(32'hFFFF_FFFF, 32'h8000_0000, "max_two");
    wait_done(100, "max_two");
  endtask

  task automatic test_start_ignored();
    lat_fixed[0] = 8;
    lat_fixed[1] = 8;
    launch(32'd192, 32'd64, "start_ignored");
    repeat (3) @(negedge clk);
    start = 1'b1;
    num_threads = 32'd640;
    block_dim = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200, "start_ignored");
  endtask

  task automatic test_mid_reset();
    lat_fixed[0] = 20;
    lat_fixed[1] = 20;
    launch(32'd4096, 32'd64, "mid_reset");
    for (int k = 0; k < 10 && core_enable !== 2'b11; k++) @(negedge clk);
    checks++;
    if (core_enable !== 2'b11) begin
      errors++;
      $display("FAIL mid_reset both_running: got en=%b required 11", core_enable);
    end
    #2 rst = 1'b0;
    #1 check_reset_values("mid_reset_async");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    lat_fixed[0] = 4;
    lat_fixed[1] = 4;
    launch(32'd128, 32'd64, "after_reset");
    wait_done(100, "after_reset");
  endtask

  task automatic test_random();
    lat_fixed[0] = 0;
    lat_fixed[1] = 0;
    for (int r = 0; r < 4; r++) begin
      logic [31:0] n, d;
      n = $urandom_range(1, 400);
      d = $urandom_range(1, 80);
      launch(n, d, "random");
      wait_done(int'(exp_nb) * 16 + 100, "random");
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_simultaneous_stale();
    test_zero_grid();
    test_start_ignored();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
